// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared types and line levels for the PISO serial transmitter
//
// Purpose: FSM state encoding, serial line levels and the even-parity helper
//          used by piso_tx_ctrl.
// Ports:   none (package).

package piso_tx_pkg;

  localparam int DATA_W = 4;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Bit that makes the total count of ones over data+parity even.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - bit-period counter producing one tick per serial bit
//
// Purpose: counts CLKS_PER_BIT clock cycles and raises tick during the last
//          cycle of each bit period; wraps to zero after a tick.
// Ports:   clk     in  rising-edge clock
//          rst     in  synchronous active-high reset
//          restart in  hold the counter at zero (bit period starts afresh)
//          tick    out high in the last cycle of the current bit period

module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int         CNT_W    = 8;
  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    // Wrapping on tick means every state change (which only happens on a
    // tick) lands on a fresh bit period without a separate restart.
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - 4-bit parallel-in serial-out frame transmitter
//
// Purpose: accepts a 4-bit word on a valid/ready handshake and sends it as
//          start bit, data MSB first, optional even parity, and 1 or 2 stop
//          bits on a registered, idle-high serial line.
// Ports:   clk        in  rising-edge clock
//          rst        in  synchronous active-high reset
//          D_in       in  parallel word to transmit
//          in_valid   in  D_in holds a valid word
//          in_ready   out word can be accepted this cycle (IDLE only)
//          serial_out out registered serial line, idle high
//          busy       out a frame is in progress
//          tx_done    out one-cycle pulse on return to IDLE after a frame

module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              tx_done
);

  // Index of the final stop bit.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]        bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              stop_idx_q, stop_idx_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;

  logic tick;
  logic restart;

  // Holding the counter at zero while idle gives START a full bit period
  // from the accepting edge; later entries coincide with the tick wrap.
  assign restart = (state_q == IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;
  assign tx_done    = done_q;

  // serial_d is the level for the next cycle, so each transition loads the
  // first bit of the state being entered.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    parity_d   = parity_q;
    stop_idx_d = stop_idx_q;
    serial_d   = serial_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d = IDLE_LEVEL;
        if (in_valid) begin
          shreg_d    = D_in;
          parity_d   = even_parity(D_in);
          bit_idx_d  = 2'd0;
          stop_idx_d = 1'b0;
          serial_d   = START_LEVEL;
          state_d    = START;
        end
      end

      START: begin
        if (tick) begin
          serial_d = shreg_q[DATA_W-1];
          state_d  = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_idx_q == 2'd3) begin
            if (PARITY_EN != 0) begin
              serial_d = parity_q;
              state_d  = PARITY;
            end else begin
              serial_d = STOP_LEVEL;
              state_d  = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 2'd1;
            serial_d  = shreg_q[DATA_W-2];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          serial_d = STOP_LEVEL;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            serial_d = IDLE_LEVEL;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end

      default: begin
        serial_d = IDLE_LEVEL;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
      stop_idx_q <= 1'b0;
      serial_q   <= IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      parity_q   <= parity_d;
      stop_idx_q <= stop_idx_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

endmodule
